// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one combinational ALU between
// two requesters. A granted operation is latched into the alu_* registers,
// the ALU result is captured one cycle later, and it is returned as a tagged,
// back-pressurable response. Opcodes the ALU does not implement are flagged.
module alu_arbiter #(
    parameter logic [7:0] ALU_SUB_IMM = 8'h01,
    parameter logic [7:0] ALU_ADD_IMM = 8'h03,
    parameter logic [7:0] ALU_OR_IMM  = 8'h08,
    parameter logic [7:0] ALU_AND_IMM = 8'h0A,
    parameter logic [7:0] ALU_XOR_IMM = 8'h0C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_opcode,
    input  logic [7:0] req0_operand_0,
    input  logic [7:0] req0_operand_1,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_opcode,
    input  logic [7:0] req1_operand_0,
    input  logic [7:0] req1_operand_1,
    output logic [7:0] alu_opcode,
    output logic [7:0] alu_operand_0,
    output logic [7:0] alu_operand_1,
    input  logic [7:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic       rsp_illegal
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_last_grant;
    logic [7:0] r_alu_opcode;
    logic [7:0] r_alu_operand_0;
    logic [7:0] r_alu_operand_1;
    logic       r_rsp_valid;
    logic       r_rsp_id;
    logic [7:0] r_rsp_result;
    logic       r_rsp_illegal;

    logic       w_can_grant;
    logic       w_winner;
    logic       w_grant;
    logic [7:0] w_sel_opcode;
    logic [7:0] w_sel_operand_0;
    logic [7:0] w_sel_operand_1;

    // True when the opcode is not one of the five operations the ALU implements.
    function automatic logic f_is_illegal(input logic [7:0] op);
        logic illegal;
        case (op)
            ALU_SUB_IMM, ALU_ADD_IMM, ALU_OR_IMM,
            ALU_AND_IMM, ALU_XOR_IMM: illegal = 1'b0;
            default:                  illegal = 1'b1;
        endcase
        return illegal;
    endfunction

    // Grant decision: a grant may happen from IDLE, or from DONE in the cycle the
    // response is consumed; contention goes to the requester not granted last.
    always_comb begin
        w_can_grant = 1'b0;
        w_winner    = 1'b0;
        if (rst) begin
            w_can_grant = 1'b0;
        end else if (r_state == ST_IDLE) begin
            w_can_grant = 1'b1;
        end else if ((r_state == ST_DONE) && rsp_ready) begin
            w_can_grant = 1'b1;
        end else begin
            w_can_grant = 1'b0;
        end
        if (req0_valid && req1_valid) begin
            w_winner = ~r_last_grant;
        end else if (req1_valid) begin
            w_winner = 1'b1;
        end else begin
            w_winner = 1'b0;
        end
    end

    assign w_grant         = w_can_grant & (req0_valid | req1_valid);
    assign req0_ready      = w_grant & ~w_winner;
    assign req1_ready      = w_grant & w_winner;
    assign w_sel_opcode    = w_winner ? req1_opcode    : req0_opcode;
    assign w_sel_operand_0 = w_winner ? req1_operand_0 : req0_operand_0;
    assign w_sel_operand_1 = w_winner ? req1_operand_1 : req0_operand_1;

    // Latch the winning operation and remember who won; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_opcode    <= 8'h00;
            r_alu_operand_0 <= 8'h00;
            r_alu_operand_1 <= 8'h00;
            r_last_grant    <= 1'b1;
        end else if (w_grant) begin
            r_alu_opcode    <= w_sel_opcode;
            r_alu_operand_0 <= w_sel_operand_0;
            r_alu_operand_1 <= w_sel_operand_1;
            r_last_grant    <= w_winner;
        end else begin
            r_alu_opcode    <= r_alu_opcode;
            r_alu_operand_0 <= r_alu_operand_0;
            r_alu_operand_1 <= r_alu_operand_1;
            r_last_grant    <= r_last_grant;
        end
    end

    // Sequencer: IDLE -> BUSY (ALU evaluates) -> DONE (response held until taken).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= 1'b0;
            r_rsp_result  <= 8'h00;
            r_rsp_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= w_grant ? ST_BUSY : ST_IDLE;
                end
                ST_BUSY: begin
                    r_rsp_result  <= alu_result;
                    r_rsp_id      <= r_last_grant;
                    r_rsp_illegal <= f_is_illegal(r_alu_opcode);
                    r_rsp_valid   <= 1'b1;
                    r_state       <= ST_DONE;
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= w_grant ? ST_BUSY : ST_IDLE;
                    end else begin
                        r_state     <= ST_DONE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign alu_opcode    = r_alu_opcode;
    assign alu_operand_0 = r_alu_operand_0;
    assign alu_operand_1 = r_alu_operand_1;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_rsp_id;
    assign rsp_result    = r_rsp_result;
    assign rsp_illegal   = r_rsp_illegal;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_ready;
    logic [7:0] req0_opcode, req0_operand_0, req0_operand_1;
    logic       req1_valid, req1_ready;
    logic [7:0] req1_opcode, req1_operand_0, req1_operand_1;
    logic [7:0] alu_opcode, alu_operand_0, alu_operand_1, alu_result;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_illegal;
    logic [7:0] rsp_result;

    int checks = 0;
    int errors = 0;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_operand_0(req0_operand_0), .req0_operand_1(req0_operand_1),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_operand_0(req1_operand_0), .req1_operand_1(req1_operand_1),
        .alu_opcode(alu_opcode), .alu_operand_0(alu_operand_0), .alu_operand_1(alu_operand_1),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_illegal(rsp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational ALU the arbiter drives.
    always_comb begin
        case (alu_opcode)
            8'h01:   alu_result = alu_operand_0 - alu_operand_1;
            8'h03:   alu_result = alu_operand_0 + alu_operand_1;
            8'h08:   alu_result = alu_operand_0 | alu_operand_1;
            8'h0A:   alu_result = alu_operand_0 & alu_operand_1;
            8'h0C:   alu_result = alu_operand_0 ^ alu_operand_1;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Runs one operation through a single requester and returns the response.
    task automatic do_op(input logic id, input logic [7:0] op, input logic [7:0] a,
                         input logic [7:0] b, output logic [7:0] res, output logic rid,
                         output logic ill, output logic ok);
        int n;
        ok = 1'b1; res = 8'h00; rid = 1'b0; ill = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_opcode = op; req1_operand_0 = a; req1_operand_1 = b;
        end else begin
            req0_valid = 1'b1; req0_opcode = op; req0_operand_0 = a; req0_operand_1 = b;
        end
        n = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) ok = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) ok = 1'b0;
        res = rsp_result; rid = rsp_id; ill = rsp_illegal;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_illegal} !== 11'h000) begin
            errors++; $display("FAIL reset_rsp: got v%b id%b r%h i%b expected all zero",
                               rsp_valid, rsp_id, rsp_result, rsp_illegal);
        end
        checks++;
        if ({alu_opcode, alu_operand_0, alu_operand_1} !== 24'h000000) begin
            errors++; $display("FAIL reset_alu: got %h %h %h expected 00 00 00",
                               alu_opcode, alu_operand_0, alu_operand_1);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_latency();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_opcode = 8'h03; req0_operand_0 = 8'h05; req0_operand_1 = 8'h03;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL lat_grant: got ready %b rsp_valid %b expected 1 0", req0_ready, rsp_valid);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_opcode = 8'hEE; req0_operand_0 = 8'h77; req0_operand_1 = 8'h66;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || alu_opcode !== 8'h03 || alu_operand_0 !== 8'h05 || alu_operand_1 !== 8'h03) begin
            errors++; $display("FAIL lat_busy: got v%b %h %h %h expected 0 03 05 03",
                               rsp_valid, alu_opcode, alu_operand_0, alu_operand_1);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 8'h08 || rsp_id !== 1'b0 || rsp_illegal !== 1'b0) begin
            errors++; $display("FAIL lat_rsp: got v%b r%h id%b i%b expected 1 08 0 0",
                               rsp_valid, rsp_result, rsp_id, rsp_illegal);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL lat_drop: got rsp_valid %b expected 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic exp_id;
        apply_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_opcode = 8'h01; req0_operand_0 = 8'h10; req0_operand_1 = 8'h01;
        req1_valid = 1'b1; req1_opcode = 8'h0C; req1_operand_0 = 8'hF0; req1_operand_1 = 8'hFF;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL rr_first: got %b%b expected 10", req0_ready, req1_ready);
        end
        for (int i = 0; i < 4; i++) begin
            exp_id = (i % 2 == 1);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++; $display("FAIL rr_busy%0d: got v%b rdy %b%b expected 0 00", i, rsp_valid, req0_ready, req1_ready);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_result !== 8'h0F ||
                (exp_id ? req0_ready : req1_ready) !== 1'b1) begin
                errors++; $display("FAIL rr_done%0d: got v%b id%b r%h rdy %b%b expected id%b r0F",
                                   i, rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready, exp_id);
            end
            if (i == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_opcode = 8'h03; req0_operand_0 = 8'h01; req0_operand_1 = 8'h02;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL bp_grant: got %b expected 1", req0_ready);
        end
        @(posedge clk); #1;
        req0_opcode = 8'h0A; req0_operand_0 = 8'hAA; req0_operand_1 = 8'h0F;
        req1_valid = 1'b1; req1_opcode = 8'h08; req1_operand_0 = 8'h12; req1_operand_1 = 8'h34;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 8'h03 || rsp_id !== 1'b0 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d: got v%b r%h id%b rdy %b%b expected 1 03 0 00",
                                   i, rsp_valid, rsp_result, rsp_id, req0_ready, req1_ready);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got %b%b expected 01", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || alu_opcode !== 8'h08 || alu_operand_0 !== 8'h12 || alu_operand_1 !== 8'h34) begin
            errors++; $display("FAIL bp_busy: got v%b %h %h %h expected 0 08 12 34",
                               rsp_valid, alu_opcode, alu_operand_0, alu_operand_1);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 8'h36 || rsp_id !== 1'b1 || rsp_illegal !== 1'b0) begin
            errors++; $display("FAIL bp_rsp: got v%b r%h id%b i%b expected 1 36 1 0",
                               rsp_valid, rsp_result, rsp_id, rsp_illegal);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ops();
        logic [7:0] res;
        logic       rid, ill, ok;
        logic [7:0] v_op  [6] = '{8'h02, 8'h08, 8'h03, 8'h01, 8'h0A, 8'h0C};
        logic [7:0] v_a   [6] = '{8'h12, 8'h12, 8'hFF, 8'h00, 8'hAA, 8'h5A};
        logic [7:0] v_b   [6] = '{8'h34, 8'h34, 8'h02, 8'h01, 8'h0F, 8'hFF};
        logic [7:0] v_res [6] = '{8'h00, 8'h36, 8'h01, 8'hFF, 8'h0A, 8'hA5};
        logic       v_ill [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_op(1'(i % 2), v_op[i], v_a[i], v_b[i], res, rid, ill, ok);
            checks++;
            if (!ok || res !== v_res[i] || ill !== v_ill[i] || rid !== 1'(i % 2)) begin
                errors++; $display("FAIL op%0d_%h: got ok%b r%h i%b id%b expected r%h i%b id%0d",
                                   i, v_op[i], ok, res, ill, rid, v_res[i], v_ill[i], i % 2);
            end
        end
    endtask

    task automatic test_reset_busy();
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req1_valid = 1'b1; req1_opcode = 8'h03; req1_operand_0 = 8'h01; req1_operand_1 = 8'h01;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("FAIL rb_grant: got %b expected 1", req1_ready);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || alu_opcode !== 8'h00) begin
                errors++; $display("FAIL rb_norsp%0d: got v%b op%h expected 0 00", i, rsp_valid, alu_opcode);
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_opcode = 8'h03; req0_operand_0 = 8'h01; req0_operand_1 = 8'h01;
        req1_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL rb_first: got %b%b expected 10", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_opcode = 8'h00; req0_operand_0 = 8'h00; req0_operand_1 = 8'h00;
        req1_valid = 1'b0; req1_opcode = 8'h00; req1_operand_0 = 8'h00; req1_operand_1 = 8'h00;
        test_reset();
        test_latency();
        test_round_robin();
        test_backpressure();
        test_ops();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
